layer_serializer: RTL

- Sits directly downstream of a neuron layer.
- Captures the layer's NN parallel neuron outputs in one cycle.
- Replays them one word per cycle as a serial stream, matching the x_in/x_valid input format of the next layer.
- Flags partial-valid vectors and vectors that arrive while the previous vector is still streaming.

---
 rtl/layer_serializer_if.sv | 24 ++
 rtl/layer_serializer.sv | 81 ++++++++
 2 files changed

// File: rtl/layer_serializer_if.sv
// Parallel neuron-vector capture port and serial word stream of a layer serializer.
interface layer_serializer_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic [dataWidth-1:0]    o_data;
  logic                    o_valid;
  logic                    o_last;
  logic                    busy;
  logic                    err_partial;
  logic                    err_overrun;

  // master: upstream layer / stream consumer side; slave: the serializer
  modport master (
    output i_valid, i_data,
    input  o_data, o_valid, o_last, busy, err_partial, err_overrun
  );
  modport slave (
    input  i_valid, i_data,
    output o_data, o_valid, o_last, busy, err_partial, err_overrun
  );
endinterface

// File: rtl/layer_serializer.sv
// Captures NN parallel neuron outputs and replays them one word per cycle (word 0 the cycle after capture).
// No backpressure: a full vector arriving mid-stream is dropped and flagged; only the final-word cycle may accept it.
module layer_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input logic            clk,
  input logic            rst,
  layer_serializer_if.slave bus
);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [dataWidth-1:0] buf_q [NN];
  logic [IW-1:0]        idx;
  logic [dataWidth-1:0] data_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 partial_q;
  logic                 overrun_q;

  logic          cap;
  logic          partial;
  logic          at_last;
  logic          load;
  logic [IW-1:0] nxt;

  assign cap     = &bus.i_valid;
  assign partial = (|bus.i_valid) && !cap;
  assign at_last = (idx == LAST_IDX);
  // A new vector is accepted when idle or in the same cycle the final word is on the output.
  assign load    = cap && ((state == IDLE) || at_last);
  assign nxt     = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      partial_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (partial)
        partial_q <= 1'b1;
      if (cap && !load)
        overrun_q <= 1'b1;

      if (load) begin
        for (int k = 0; k < NN; k++)
          buf_q[k] <= bus.i_data[k*dataWidth +: dataWidth];
        // word 0 goes straight out so it appears the cycle after capture
        data_q  <= bus.i_data[dataWidth-1:0];
        valid_q <= 1'b1;
        last_q  <= (LAST_IDX == '0);
        idx     <= '0;
        state   <= SEND;
      end else if (state == SEND && !at_last) begin
        data_q  <= buf_q[nxt];
        valid_q <= 1'b1;
        last_q  <= (nxt == LAST_IDX);
        idx     <= nxt;
      end else begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        state   <= IDLE;
      end
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_last      = last_q;
  assign bus.busy        = valid_q;
  assign bus.err_partial = partial_q;
  assign bus.err_overrun = overrun_q;
endmodule
